// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, bus widths and arbiter enums shared by the port arbiter
package fb_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int AW        = 19;
  localparam int DW        = 8;

  localparam logic [AW-1:0] FB_LIMIT = AW'(FB_WORDS);

  typedef enum logic {NORM, FORCE} arb_state_t;
  typedef enum logic {OWN_D, OWN_P} owner_t;

  // Plain unsigned compare; addresses past the last pixel never wrap back in.
  function automatic logic addr_in_fb(input logic [AW-1:0] addr);
    return addr < FB_LIMIT;
  endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - display/pixel-op requester and BRAM port bundle of the framebuffer arbiter
interface fb_port_arbiter_if;
  import fb_pkg::*;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          p_req;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_gnt;
  logic          p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          p_err;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output d_req, d_addr, p_req, p_we, p_addr, p_wdata, mem_rdata,
    input  d_gnt, d_rvalid, d_rdata, p_gnt, p_rvalid, p_rdata, p_err,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  d_req, d_addr, p_req, p_we, p_addr, p_wdata, mem_rdata,
    output d_gnt, d_rvalid, d_rdata, p_gnt, p_rvalid, p_rdata, p_err,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_rd_tag_pipe.sv
// rtl/fb_rd_tag_pipe.sv - two-stage read tag shift register aligning owner/valid with BRAM read data
module fb_rd_tag_pipe
  import fb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  owner_t in_owner,
  input  logic   in_zero,
  output logic   out_valid,
  output owner_t out_owner,
  output logic   out_zero
);
  logic   s1_valid;
  owner_t s1_owner;
  logic   s1_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_owner  <= OWN_D;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_owner <= OWN_D;
      out_zero  <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_owner  <= in_owner;
      s1_zero   <= in_zero;
      out_valid <= s1_valid;
      out_owner <= s1_owner;
      out_zero  <= s1_zero;
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - framebuffer BRAM port arbiter: display priority with a pixel-op starvation guard
// Defining FB_ARB_STATS_EN adds grant and FORCE-entry counters.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int MAX_STARVE = 15
) (
  input  logic             clk,
  input  logic             rst,
  fb_port_arbiter_if.slave bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]      stat_d_cnt,
  output logic [31:0]      stat_p_cnt,
  output logic [15:0]      stat_force_cnt
`endif
);
  localparam logic [7:0] STARVE_MAX = 8'(MAX_STARVE);

  arb_state_t    state;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_nxt;
  logic          enter_force;

  logic          d_gnt;
  logic          p_gnt;
  logic          d_acc;
  logic          p_acc;
  logic          d_ok;
  logic          p_ok;

  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic          p_err_q;

  logic          tag_in_valid;
  owner_t        tag_in_owner;
  logic          tag_in_zero;
  logic          tag_valid;
  owner_t        tag_owner;
  logic          tag_zero;

  always_comb begin
    d_gnt = (state == NORM) && bus.d_req;
    p_gnt = (state == FORCE) || (bus.p_req && !bus.d_req);
    d_acc = d_gnt;
    p_acc = bus.p_req && p_gnt;
    d_ok  = addr_in_fb(bus.d_addr);
    p_ok  = addr_in_fb(bus.p_addr);

    starve_nxt = starve_cnt;
    if (p_gnt) begin
      starve_nxt = 8'd0;
    end else if (bus.p_req && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + 8'd1;
    end
    // Look at the next count so the forced slot lands right after the last denied cycle.
    enter_force = (state == NORM) && (starve_nxt == STARVE_MAX);

    // Out-of-range P accesses are dropped; out-of-range D reads still answer, with zero data.
    tag_in_valid = d_acc || (p_acc && p_ok && !bus.p_we);
    tag_in_owner = d_acc ? OWN_D : OWN_P;
    tag_in_zero  = d_acc && !d_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NORM;
      starve_cnt  <= 8'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      p_err_q     <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      mem_we_q   <= 1'b0;
      p_err_q    <= 1'b0;
      case (state)
        NORM:    if (enter_force) state <= FORCE;
        default: state <= NORM;
      endcase
      if (d_acc) begin
        mem_addr_q <= bus.d_addr;
      end else if (p_acc) begin
        if (p_ok) begin
          mem_addr_q <= bus.p_addr;
          mem_we_q   <= bus.p_we;
          if (bus.p_we) mem_wdata_q <= bus.p_wdata;
        end else begin
          p_err_q <= 1'b1;
        end
      end
    end
  end

  fb_rd_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_in_valid),
    .in_owner  (tag_in_owner),
    .in_zero   (tag_in_zero),
    .out_valid (tag_valid),
    .out_owner (tag_owner),
    .out_zero  (tag_zero)
  );

  assign bus.d_gnt     = d_gnt;
  assign bus.p_gnt     = p_gnt;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p_err     = p_err_q;

  assign bus.d_rvalid = tag_valid && (tag_owner == OWN_D);
  assign bus.p_rvalid = tag_valid && (tag_owner == OWN_P);
  assign bus.d_rdata  = (bus.d_rvalid && !tag_zero) ? bus.mem_rdata : '0;
  assign bus.p_rdata  = bus.p_rvalid ? bus.mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_d_cnt     <= 32'd0;
      stat_p_cnt     <= 32'd0;
      stat_force_cnt <= 16'd0;
    end else begin
      if (d_acc)       stat_d_cnt     <= stat_d_cnt + 32'd1;
      if (p_acc)       stat_p_cnt     <= stat_p_cnt + 32'd1;
      if (enter_force) stat_force_cnt <= stat_force_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - randomized self-checking bench for fb_port_arbiter against a grant/scoreboard model
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int MAX_STARVE = 15;
  localparam int MEM_SZ     = 1 << 19;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_port_arbiter_if bus();

`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_d_cnt;
  logic [31:0] stat_p_cnt;
  logic [15:0] stat_force_cnt;
`endif

  fb_port_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FB_ARB_STATS_EN
    , .stat_d_cnt     (stat_d_cnt)
    , .stat_p_cnt     (stat_p_cnt)
    , .stat_force_cnt (stat_force_cnt)
`endif
  );

  logic [7:0] bram    [MEM_SZ] = '{default: 8'h00};
  logic [7:0] ref_mem [MEM_SZ] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bram[bus.mem_addr];
  end

  typedef struct { logic we; logic [18:0] addr; logic [7:0] wdata; } p_op_t;
  typedef struct { int due; bit own_p; logic [7:0] data; } rd_exp_t;

  logic [18:0] d_q[$];
  p_op_t       p_q[$];
  rd_exp_t     sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int p_wait = 0;
  int m_d_cnt = 0, m_p_cnt = 0, m_force_cnt = 0;
  bit nx_iss = 0, nx_we = 0, nx_err = 0;
  logic [18:0] nx_addr = '0;
  logic [7:0]  nx_wdata = '0;

  function automatic bit in_fb(input logic [18:0] a);
    return int'(a) < 640 * 480;
  endfunction

  function automatic logic [18:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 19'h4AFFF;
    if (r == 1) return 19'h4B000;
    if (r == 2) return 19'h7FFFF;
    return 19'($urandom_range(0, 31));
  endfunction

  task automatic model_clear();
    d_q.delete(); p_q.delete(); sb.delete();
    p_wait = 0; nx_iss = 0; nx_we = 0; nx_err = 0;
    m_d_cnt = 0; m_p_cnt = 0; m_force_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.d_req = 1'b0; bus.d_addr = '0;
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
  endtask

  // One clock cycle: drive requests from the queues, compare against the model, advance the model.
  task automatic step();
    bit cur_iss, cur_we, cur_err, forced, exp_dg, exp_pg, exp_drv, exp_prv;
    logic [18:0] cur_addr, a;
    logic [7:0] cur_wdata, exp_drd, exp_prd;
    rd_exp_t e;
    p_op_t op;
    @(negedge clk);
    cyc++;
    bus.d_req  = d_q.size() > 0;
    bus.d_addr = (d_q.size() > 0) ? d_q[0] : '0;
    if (p_q.size() > 0) begin
      bus.p_req = 1'b1; bus.p_we = p_q[0].we; bus.p_addr = p_q[0].addr; bus.p_wdata = p_q[0].wdata;
    end else begin
      bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    end
    #1;
    cur_iss = nx_iss; cur_we = nx_we; cur_err = nx_err; cur_addr = nx_addr; cur_wdata = nx_wdata;
    forced = (p_q.size() > 0) && (p_wait == MAX_STARVE);
    exp_pg = (p_q.size() > 0) && ((d_q.size() == 0) || forced);
    exp_dg = (d_q.size() > 0) && !forced;
    exp_drv = 0; exp_prv = 0; exp_drd = 8'h00; exp_prd = 8'h00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.own_p) begin exp_prv = 1; exp_prd = e.data; end
      else begin exp_drv = 1; exp_drd = e.data; end
    end

    checks++; if (bus.d_gnt !== exp_dg) begin failures++; $display("FAIL d_gnt cyc=%0d got=%b exp=%b", cyc, bus.d_gnt, exp_dg); end
    checks++; if (bus.p_gnt !== exp_pg) begin failures++; $display("FAIL p_gnt cyc=%0d got=%b exp=%b", cyc, bus.p_gnt, exp_pg); end
    checks++; if (bus.d_rvalid !== exp_drv) begin failures++; $display("FAIL d_rvalid cyc=%0d got=%b exp=%b", cyc, bus.d_rvalid, exp_drv); end
    checks++; if (bus.d_rdata !== exp_drd) begin failures++; $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, bus.d_rdata, exp_drd); end
    checks++; if (bus.p_rvalid !== exp_prv) begin failures++; $display("FAIL p_rvalid cyc=%0d got=%b exp=%b", cyc, bus.p_rvalid, exp_prv); end
    checks++; if (bus.p_rdata !== exp_prd) begin failures++; $display("FAIL p_rdata cyc=%0d got=%h exp=%h", cyc, bus.p_rdata, exp_prd); end
    checks++; if (bus.p_err !== cur_err) begin failures++; $display("FAIL p_err cyc=%0d got=%b exp=%b", cyc, bus.p_err, cur_err); end
    checks++; if (bus.mem_we !== cur_we) begin failures++; $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, cur_we); end
    if (cur_iss) begin
      checks++; if (bus.mem_addr !== cur_addr) begin failures++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, cur_addr); end
    end
    if (cur_we) begin
      checks++; if (bus.mem_wdata !== cur_wdata) begin failures++; $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, cur_wdata); end
    end

    nx_iss = 0; nx_we = 0; nx_err = 0;
    if (exp_dg) begin
      a = d_q.pop_front();
      m_d_cnt++;
      e.due = cyc + 2; e.own_p = 0; e.data = in_fb(a) ? ref_mem[a] : 8'h00;
      sb.push_back(e);
      nx_iss = 1; nx_addr = a;
    end
    if (exp_pg) begin
      op = p_q.pop_front();
      m_p_cnt++;
      if (forced) m_force_cnt++;
      if (!in_fb(op.addr)) begin
        nx_err = 1;
      end else begin
        nx_iss = 1; nx_addr = op.addr;
        if (op.we) begin
          nx_we = 1; nx_wdata = op.wdata; ref_mem[op.addr] = op.wdata;
        end else begin
          e.due = cyc + 2; e.own_p = 1; e.data = ref_mem[op.addr];
          sb.push_back(e);
        end
      end
    end
    if ((p_q.size() > 0 || exp_pg) && !exp_pg) p_wait++;
    else p_wait = 0;
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while ((d_q.size() > 0 || p_q.size() > 0 || sb.size() > 0 || nx_iss || nx_err) && k < limit) begin
      step();
      k++;
    end
    checks++;
    if (k >= limit) begin failures++; $display("FAIL %s_drain cycles=%0d limit=%0d", name, k, limit); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("FAIL rst_d_gnt got=%b exp=0", bus.d_gnt); end
    checks++; if (bus.p_gnt !== 1'b0) begin failures++; $display("FAIL rst_p_gnt got=%b exp=0", bus.p_gnt); end
    checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_d_rvalid got=%b exp=0", bus.d_rvalid); end
    checks++; if (bus.p_rvalid !== 1'b0) begin failures++; $display("FAIL rst_p_rvalid got=%b exp=0", bus.p_rvalid); end
    checks++; if (bus.d_rdata !== 8'h00) begin failures++; $display("FAIL rst_d_rdata got=%h exp=00", bus.d_rdata); end
    checks++; if (bus.p_rdata !== 8'h00) begin failures++; $display("FAIL rst_p_rdata got=%h exp=00", bus.p_rdata); end
    checks++; if (bus.p_err !== 1'b0) begin failures++; $display("FAIL rst_p_err got=%b exp=0", bus.p_err); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 19'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=00", bus.mem_wdata); end
`ifdef FB_ARB_STATS_EN
    checks++; if (stat_d_cnt !== 32'd0 || stat_p_cnt !== 32'd0 || stat_force_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_stats got=%0d/%0d/%0d exp=0/0/0", stat_d_cnt, stat_p_cnt, stat_force_cnt);
    end
`endif
    rst = 1'b0;
    repeat (100) step();
  endtask

  task automatic test_starvation();
    int t0;
    int g[$];
    p_op_t op;
    for (int i = 0; i < 80; i++) d_q.push_back(19'($urandom_range(0, 63)));
    for (int i = 0; i < 4; i++) begin
      op.we = 1'b0; op.addr = 19'h00010; op.wdata = 8'h00;
      p_q.push_back(op);
    end
    t0 = cyc + 1;
    for (int k = 0; k < 200 && p_q.size() > 0; k++) begin
      step();
      if (bus.p_gnt === 1'b1) g.push_back(cyc);
    end
    checks++;
    if (g.size() != 4) begin
      failures++; $display("FAIL starve_grant_count got=%0d exp=4", g.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] != t0 + 15 + 16 * i) begin
          failures++; $display("FAIL starve_slot%0d got=%0d exp=%0d", i, g[i] - t0, 15 + 16 * i);
        end
      end
    end
    drain("starve", 200);
  endtask

  task automatic test_read_after_write();
    int rg, rv;
    logic [7:0] rd;
    p_op_t op;
    rg = -1; rv = -1; rd = 8'h00;
    op.we = 1'b1; op.addr = 19'h4AFFF; op.wdata = 8'hA5; p_q.push_back(op);
    op.we = 1'b0; op.wdata = 8'h00; p_q.push_back(op);
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.p_gnt === 1'b1 && bus.p_req === 1'b1 && bus.p_we === 1'b0) rg = cyc;
      if (bus.p_rvalid === 1'b1) begin rv = cyc; rd = bus.p_rdata; end
    end
    checks++; if (rg < 0 || rv != rg + 2) begin failures++; $display("FAIL raw_latency got=%0d exp=%0d", rv - rg, 2); end
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL raw_data got=%h exp=a5", rd); end
    drain("raw", 50);
  endtask

  task automatic test_out_of_range();
    int gc, ec, errs, wes;
    logic [7:0] orig;
    p_op_t op;
    gc = -1; ec = -1; errs = 0; wes = 0;
    orig = bram[19'h4B000];
    op.we = 1'b1; op.addr = 19'h4B000; op.wdata = ~orig; p_q.push_back(op);
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.p_gnt === 1'b1 && bus.p_req === 1'b1) gc = cyc;
      if (bus.p_err === 1'b1) begin errs++; ec = cyc; end
      if (bus.mem_we === 1'b1) wes++;
    end
    checks++; if (errs != 1) begin failures++; $display("FAIL oor_err_pulses got=%0d exp=1", errs); end
    checks++; if (gc < 0 || ec != gc + 1) begin failures++; $display("FAIL oor_err_timing got=%0d exp=%0d", ec - gc, 1); end
    checks++; if (wes != 0) begin failures++; $display("FAIL oor_mem_we got=%0d exp=0", wes); end
    checks++; if (bram[19'h4B000] !== orig) begin failures++; $display("FAIL oor_bram got=%h exp=%h", bram[19'h4B000], orig); end
    d_q.push_back(19'h7FFFF);
    op.we = 1'b0; op.addr = 19'h4B001; op.wdata = 8'h00; p_q.push_back(op);
    drain("oor", 50);
  endtask

  task automatic test_back_to_back();
    logic [7:0] wd [3];
    int vc[$];
    logic [7:0] vd[$];
    int prv;
    p_op_t op;
    prv = 0;
    for (int i = 0; i < 3; i++) begin
      wd[i] = 8'($urandom);
      op.we = 1'b1; op.addr = 19'(i); op.wdata = wd[i]; p_q.push_back(op);
    end
    drain("b2b_fill", 50);
    for (int i = 0; i < 3; i++) d_q.push_back(19'(i));
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.d_rvalid === 1'b1) begin vc.push_back(cyc); vd.push_back(bus.d_rdata); end
      if (bus.p_rvalid === 1'b1) prv++;
    end
    checks++;
    if (vc.size() != 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", vc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (vd[i] !== wd[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, vd[i], wd[i]); end
      end
      checks++; if (vc[2] - vc[0] != 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=2", vc[2] - vc[0]); end
    end
    checks++; if (prv != 0) begin failures++; $display("FAIL b2b_p_rvalid got=%0d exp=0", prv); end
  endtask

  task automatic test_random();
    p_op_t op;
    for (int k = 0; k < 400; k++) begin
      if (d_q.size() == 0 && $urandom_range(0, 2) == 0) d_q.push_back(rand_addr());
      if (p_q.size() == 0 && $urandom_range(0, 1) == 0) begin
        op.we = 1'($urandom_range(0, 1)); op.addr = rand_addr(); op.wdata = 8'($urandom);
        p_q.push_back(op);
      end
      step();
    end
    drain("random", 100);
  endtask

  task automatic test_reset_inflight();
    int t0, gc, rvs;
    p_op_t op;
    gc = -1; rvs = 0;
    for (int i = 0; i < 10; i++) d_q.push_back(19'($urandom_range(0, 31)));
    op.we = 1'b0; op.addr = 19'h00003; op.wdata = 8'h00; p_q.push_back(op);
    repeat (6) step();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    for (int k = 0; k < 4; k++) begin
      if (bus.d_rvalid === 1'b1 || bus.p_rvalid === 1'b1 || bus.mem_we === 1'b1) rvs++;
      @(negedge clk); #1;
    end
    checks++; if (rvs != 0) begin failures++; $display("FAIL rstfl_activity got=%0d exp=0", rvs); end
`ifdef FB_ARB_STATS_EN
    checks++; if (stat_d_cnt !== 32'd0 || stat_p_cnt !== 32'd0 || stat_force_cnt !== 16'd0) begin
      failures++; $display("FAIL rstfl_stats got=%0d/%0d/%0d exp=0/0/0", stat_d_cnt, stat_p_cnt, stat_force_cnt);
    end
`endif
    rst = 1'b0;
    for (int i = 0; i < 20; i++) d_q.push_back(19'($urandom_range(0, 31)));
    p_q.push_back(op);
    t0 = cyc + 1;
    for (int k = 0; k < 40 && p_q.size() > 0; k++) begin
      step();
      if (bus.p_gnt === 1'b1) gc = cyc;
    end
    checks++; if (gc != t0 + 15) begin failures++; $display("FAIL rstfl_starve_slot got=%0d exp=15", gc - t0); end
    drain("rstfl", 100);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_starvation();
    test_read_after_write();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_inflight();
`ifdef FB_ARB_STATS_EN
    @(negedge clk); #1;
    checks++; if (stat_d_cnt !== 32'(m_d_cnt)) begin failures++; $display("FAIL stat_d got=%0d exp=%0d", stat_d_cnt, m_d_cnt); end
    checks++; if (stat_p_cnt !== 32'(m_p_cnt)) begin failures++; $display("FAIL stat_p got=%0d exp=%0d", stat_p_cnt, m_p_cnt); end
    checks++; if (stat_force_cnt !== 16'(m_force_cnt)) begin failures++; $display("FAIL stat_force got=%0d exp=%0d", stat_force_cnt, m_force_cnt); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
